// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the 16x16 register group with pending-write scoreboard.
// Define REG_WRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module reg_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      claim_valid,
    input  logic [ADDR_W-1:0]         claim_addr,
    input  logic [ADDR_W-1:0]         rd_a,
    input  logic [ADDR_W-1:0]         rd_b,
    output logic                      stall,
    output logic [2**ADDR_W-1:0]      busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [PTR_W-1:0]  g_idx;
    logic              transfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] ptr_reg;

    // Scan starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr_reg) + k) % NUM_REQ);
            if (req[idx] && !found) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else if (transfer) begin
            ptr_reg <= (g_idx == PTR_W'(NUM_REQ-1)) ? '0 : g_idx + PTR_W'(1);
        end
    end
`endif

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) g_idx = PTR_W'(i);
        end
    end

    assign transfer = |(req & grant);
    assign sel_addr = addr_arr[g_idx];
    assign sel_data = data_arr[g_idx];

    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;

    // R0 transfers are consumed but never strobe the register group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= transfer && (sel_addr != '0);
            if (transfer) begin
                wr_addr_reg <= sel_addr;
                wr_data_reg <= sel_data;
            end
        end
    end

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    // Clear on commit first, then set on claim so a same-edge claim wins.
    always_comb begin
        busy_next = busy_reg;
        if (transfer && (sel_addr != '0)) busy_next[sel_addr] = 1'b0;
        if (claim_valid && (claim_addr != '0)) busy_next[claim_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign busy    = busy_reg;
    assign stall   = busy_reg[rd_a] | busy_reg[rd_b];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed vector table, async-reset sequence,
// and randomized traffic against a behavioural model.
module tb_reg_write_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*4-1:0]  req_addr = '0;
    logic [N*16-1:0] req_data = '0;
    logic [N-1:0]  grant;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [15:0]   wr_data;
    logic          claim_valid = 1'b0;
    logic [3:0]    claim_addr = '0;
    logic [3:0]    rd_a = '0;
    logic [3:0]    rd_b = '0;
    logic          stall;
    logic [15:0]   busy;

    int n_checks = 0;
    int n_fail   = 0;

    reg_write_arbiter #(.NUM_REQ(N), .DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .grant(grant), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .rd_a(rd_a), .rd_b(rd_b),
        .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        do_rst;
        logic [2:0]  req;
        logic [11:0] addr;
        logic [47:0] data;
        logic        cv;
        logic [3:0]  ca;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  e_grant;
        logic        e_wr_en;
        logic [3:0]  e_wr_addr;
        logic [15:0] e_wr_data;
        logic [15:0] e_busy;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [2:0] rq, logic [11:0] a, logic [47:0] d,
                                logic cv, logic [3:0] ca, logic [3:0] ra, logic [3:0] rb,
                                logic [2:0] eg, logic ew, logic [3:0] ewa, logic [15:0] ewd,
                                logic [15:0] eb, logic es);
        vec_t v;
        v.do_rst = r; v.req = rq; v.addr = a; v.data = d;
        v.cv = cv; v.ca = ca; v.ra = ra; v.rb = rb;
        v.e_grant = eg; v.e_wr_en = ew; v.e_wr_addr = ewa; v.e_wr_data = ewd;
        v.e_busy = eb; v.e_stall = es;
        return v;
    endfunction

    task automatic pulse_reset();
        rst = 1'b0;
        req = '0; claim_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Behavioural model state for the random phase
    int          m_ptr;
    logic [15:0] m_busy;
    logic        m_wr_en;
    logic [3:0]  m_wr_addr;
    logic [15:0] m_wr_data;
    logic        r_req  [N];
    logic [3:0]  r_addr [N];
    logic [15:0] r_data [N];

    initial begin
        logic [3:0]  a8;
        logic [15:0] d8;
        // Contention expectations differ between round-robin and fixed priority
`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
        a8 = 4'd1; d8 = 16'h0011;
`else
        a8 = 4'd3; d8 = 16'h0033;
`endif
        //            rst req    addr     data               cv ca  ra  rb   grant  we  wa   wd        busy     st
        vecs.push_back(mk(1, 3'b001, 12'h003, 48'h1234, 0, 0, 0, 0, 3'b001, 0, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    0, 0, 0, 0, 3'b000, 1, 3, 16'h1234, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    0, 0, 0, 0, 3'b000, 0, 3, 16'h1234, 16'h0000, 0));
        vecs.push_back(mk(1, 3'b111, 12'h321, 48'h0033_0022_0011, 0, 0, 0, 0, 3'b001, 0, 0, 16'h0000, 16'h0000, 0));
`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
        vecs.push_back(mk(0, 3'b111, 12'h321, 48'h0033_0022_0011, 0, 0, 0, 0, 3'b001, 1, 1, 16'h0011, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b111, 12'h321, 48'h0033_0022_0011, 0, 0, 0, 0, 3'b001, 1, 1, 16'h0011, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    0, 0, 0, 0, 3'b000, 1, 1, 16'h0011, 16'h0000, 0));
`else
        vecs.push_back(mk(0, 3'b111, 12'h321, 48'h0033_0022_0011, 0, 0, 0, 0, 3'b010, 1, 1, 16'h0011, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b111, 12'h321, 48'h0033_0022_0011, 0, 0, 0, 0, 3'b100, 1, 2, 16'h0022, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    0, 0, 0, 0, 3'b000, 1, 3, 16'h0033, 16'h0000, 0));
`endif
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    0, 0, 0, 0, 3'b000, 0, a8, d8, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b010, 12'h000, 48'h0000_FFFF_0000, 0, 0, 0, 0, 3'b010, 0, a8, d8, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    1, 5, 5, 0, 3'b000, 0, 0, 16'hFFFF, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    0, 0, 5, 0, 3'b000, 0, 0, 16'hFFFF, 16'h0020, 1));
        vecs.push_back(mk(0, 3'b001, 12'h005, 48'h0055, 0, 0, 5, 0, 3'b001, 0, 0, 16'hFFFF, 16'h0020, 1));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    0, 0, 5, 0, 3'b000, 1, 5, 16'h0055, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    1, 7, 0, 0, 3'b000, 0, 5, 16'h0055, 16'h0000, 0));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    0, 0, 0, 0, 3'b000, 0, 5, 16'h0055, 16'h0080, 0));
        vecs.push_back(mk(0, 3'b001, 12'h007, 48'h0077, 1, 7, 0, 7, 3'b001, 0, 5, 16'h0055, 16'h0080, 1));
        vecs.push_back(mk(0, 3'b000, 12'h000, 48'h0,    0, 0, 0, 7, 3'b000, 1, 7, 16'h0077, 16'h0080, 1));

        // Reset state straight out of asynchronous reset
        #3;
        check("reset_wr_en", 64'(wr_en), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // ---------------- directed table ----------------
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) pulse_reset();
            req = vecs[i].req; req_addr = vecs[i].addr; req_data = vecs[i].data;
            claim_valid = vecs[i].cv; claim_addr = vecs[i].ca;
            rd_a = vecs[i].ra; rd_b = vecs[i].rb;
            @(negedge clk);
            check($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].e_grant));
            check($sformatf("vec%0d_wr_en", i), 64'(wr_en), 64'(vecs[i].e_wr_en));
            check($sformatf("vec%0d_wr_addr", i), 64'(wr_addr), 64'(vecs[i].e_wr_addr));
            check($sformatf("vec%0d_wr_data", i), 64'(wr_data), 64'(vecs[i].e_wr_data));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
            $display("vec %0d: req=%b grant=%b wr_en=%b wr_addr=%0d wr_data=%h busy=%h stall=%b",
                     i, req, grant, wr_en, wr_addr, wr_data, busy, stall);
            @(posedge clk);
            #1;
        end

        // ---------------- async reset mid-operation ----------------
        req = '0; rd_a = '0; rd_b = '0;
        claim_valid = 1'b1;
        claim_addr = 4'd2; @(posedge clk); #1;
        claim_addr = 4'd5; @(posedge clk); #1;
        claim_addr = 4'd7; @(posedge clk); #1;
        claim_valid = 1'b0;
        req = 3'b001; req_addr = 12'h003; req_data = 48'hABCD;
        @(negedge clk);
        check("arst_pre_busy", 64'(busy), 64'h00A4);
        check("arst_pre_grant", 64'(grant), 64'b001);
        @(posedge clk);
        #1 req = '0;
        check("arst_wr_en_before", 64'(wr_en), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_wr_en", 64'(wr_en), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_wr_addr", 64'(wr_addr), 64'd0);
        $display("async reset: wr_en=%b busy=%h", wr_en, busy);
        @(posedge clk);
        #1 rst = 1'b1;

        // ---------------- randomized traffic vs model ----------------
        m_ptr = 0; m_busy = '0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int g;
            logic [15:0] nb;
            for (int i = 0; i < N; i++) begin
                if (!r_req[i]) begin
                    r_req[i]  = ($urandom_range(0, 99) < 45);
                    r_addr[i] = 4'($urandom_range(0, 15));
                    r_data[i] = 16'($urandom);
                end
            end
            req = {r_req[2], r_req[1], r_req[0]};
            req_addr = {r_addr[2], r_addr[1], r_addr[0]};
            req_data = {r_data[2], r_data[1], r_data[0]};
            claim_valid = ($urandom_range(0, 99) < 40);
            claim_addr = 4'($urandom_range(0, 15));
            rd_a = 4'($urandom_range(0, 15));
            rd_b = 4'($urandom_range(0, 15));

            // Expected winner: first requester at or after the pointer, wrapping.
            g = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (r_req[j] && g < 0) g = j;
            end

            @(negedge clk);
            check("rnd_grant", 64'(grant), (g < 0) ? 64'd0 : (64'd1 << g));
            check("rnd_wr_en", 64'(wr_en), 64'(m_wr_en));
            check("rnd_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
            check("rnd_wr_data", 64'(wr_data), 64'(m_wr_data));
            check("rnd_busy", 64'(busy), 64'(m_busy));
            check("rnd_stall", 64'(stall), 64'(m_busy[rd_a] | m_busy[rd_b]));

            nb = m_busy;
            if (g >= 0) begin
                $display("rnd %0d: grant to %0d addr=%0d data=%h", cyc, g, r_addr[g], r_data[g]);
                m_wr_en   = (r_addr[g] != 0);
                m_wr_addr = r_addr[g];
                m_wr_data = r_data[g];
                if (r_addr[g] != 0) nb[r_addr[g]] = 1'b0;
`ifndef REG_WRITE_ARB_FIXED_PRIO_EN
                m_ptr = (g + 1) % N;
`endif
                r_req[g] = 1'b0;
            end else begin
                m_wr_en = 1'b0;
            end
            if (claim_valid && claim_addr != 0) nb[claim_addr] = 1'b1;
            m_busy = nb;

            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
